output_port_ctrl: RTL and testbench
===================================

Name: output_port_ctrl

Overview:
- Per-output-port controller of the NoC router; the transmit end of the link whose receive end is the router input queue.
- Arbitrates among the P input queues requesting this output port using round-robin, gated by downstream credit.
- Captures the granted flit from the crossbar and drives flit_out_wr/flit_out to the downstream input queue.
- Tracks downstream buffer occupancy with a credit counter that is replenished by the downstream flit_rel pulse.

Parameters:
- FW, 64, flit width in bits.
- P, 7, number of router ports, which is also the number of requesters.
- B, 4, downstream buffer address width.
- CREDITS, 16, initial credit count; equals the downstream buffer depth, 1<<B.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  P  bit i = input queue i requests this output (its dest_port_req bit for this port).
- flit_in  input  P*FW  crossbar flits; input i occupies [i*FW +: FW].
- grant  output  P  one-hot grant to input i; returned as that queue's grant_dest_port bit.
- flit_out_wr  output  1  flit valid to downstream; one-cycle pulse per flit.
- flit_out  output  FW  flit to downstream input queue.
- credit_in  input  1  downstream flit_rel; one credit returned per asserted cycle.
- credit_cnt  output  B+1  current credit count, for debug/perf.
- cred_err  output  1  sticky error: credit overflow.

Behaviour:
- Reset values: grant=0, flit_out_wr=0, flit_out=0, credit_cnt=CREDITS, cred_err=0, RR pointer last=P-1, so input 0 has first priority.
- grant is combinational within the request cycle, because the input queue consumes grant on the same edge (its request drops the next cycle).
  - grant = rr_pick(req) when credit_cnt != 0; otherwise 0.
  - At most one bit is set.
  - grant never asserts while rst_n is low.
- Round-robin: search starts at index (last+1) mod P and wraps. On any grant, last <= granted index. With no grant, last holds.
- Data path, 1-cycle latency: on a grant edge, flit_out <= flit_in[g*FW +: FW] and flit_out_wr <= 1. Otherwise flit_out_wr <= 0 and flit_out holds its value.
- Back-to-back grants are allowed every cycle, giving one flit per cycle while credits last.
- Credit counter, B+1 bits:
  - Decrement on grant; increment on credit_in.
  - Both in the same cycle: count unchanged.
  - credit_cnt=0: no grant; a credit_in in that cycle raises the count to 1 and the grant can issue the next cycle. There is no same-cycle bypass.
  - credit_in while credit_cnt==CREDITS (and no grant): count saturates at CREDITS and cred_err <= 1, sticky until reset.
- Multicast: each output port arbitrates independently. A requester that loses simply keeps req high. There is no fairness interaction across ports.
- A req bit that drops without a grant is legal; the arbiter ignores it next cycle.
- Reset mid-operation: all state returns to reset values immediately (async). Any in-flight flit_out_wr pulse is dropped. Credits return to CREDITS, which is consistent because the downstream queue is reset in the same domain.
- All arithmetic is unsigned, and the index computation wraps mod P. Non-power-of-2 P must work (default 7).

Decomposition:
- No shared typedefs are needed. CREDITS derives from B at instantiation; the flit field constants remain in the router-level header.
- One natural sub-module, rr_arbiter #(P): inputs clk, rst_n, req, advance; outputs a one-hot grant. It holds the pointer and combinational priority logic.
- output_port_ctrl adds the credit gate, output register and error flag.

Test Plan:
- Single request: reset, req=7'b0000100, flit_in[2]=A. Response: grant=0000100 in that cycle; next cycle flit_out_wr=1, flit_out=A; credit_cnt 16->15.
- Round-robin: req=7'b1111111 held for 8 cycles, credit_in=0. Response: grants in order 0,1,2,3,4,5,6,0; credit_cnt ends at 8.
- Credit exhaustion: single requester held, no credit_in. Response: 16 flits sent, grant=0 from the 17th cycle; one credit_in pulse gives exactly one grant on the following cycle.
- Simultaneous: credit_cnt=5, grant and credit_in in the same cycle. Response: credit_cnt stays 5; run 20 cycles of streaming with credit_in echoing flit_out_wr delayed 3 cycles, with no stall after warm-up.
- Overflow: after reset, pulse credit_in with no traffic. Response: credit_cnt stays 16, cred_err=1 and remains 1 until rst_n.
- Async reset mid-stream: assert rst_n low between clock edges while flit_out_wr=1. Response: flit_out_wr, grant and cred_err go to 0 and credit_cnt to 16 immediately; after release, input 0 wins first.

Source files
------------

// File: rtl/output_port_ctrl_pkg.sv
// Shared defaults and small helpers for the router output-port controller.
package output_port_ctrl_pkg;

  localparam int unsigned DEF_FW = 64;
  localparam int unsigned DEF_P  = 7;
  localparam int unsigned DEF_B  = 4;

  // Width needed to hold an index in [0, n-1]; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_port_ctrl_rr.sv
// Round-robin arbiter: holds the last-granted pointer and picks the first
// requester after it, wrapping mod P. The grant is combinational in the
// request cycle; the pointer moves only when a grant actually issues.
module rr_arbiter
  import output_port_ctrl_pkg::*;
#(
  parameter int unsigned P = DEF_P
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [P-1:0] req,
  input  logic         advance,
  output logic [P-1:0] grant
);

  localparam int unsigned     LW       = idx_w(P);
  localparam logic [LW-1:0]   LAST_RST = LW'(P - 1);

  logic [LW-1:0] last_q;
  logic [LW-1:0] last_d;
  logic [P-1:0]  pick;
  logic [LW-1:0] pick_idx;
  logic          found;
  int unsigned   idx;
  logic [LW-1:0] idx_l;

  // Priority search starting one past the last winner, wrapping mod P.
  always_comb begin
    pick     = '0;
    pick_idx = last_q;
    found    = 1'b0;
    idx      = 0;
    idx_l    = '0;
    for (int unsigned off = 1; off <= P; off++) begin
      idx = 32'(last_q) + off;
      if (idx >= P) begin
        idx = idx - P;
      end
      idx_l = LW'(idx);
      if (!found && req[idx_l]) begin
        found       = 1'b1;
        pick[idx_l] = 1'b1;
        pick_idx    = idx_l;
      end
    end
  end

  // Reset is folded in so the grant cannot escape while rst_n is low.
  assign grant = (advance && rst_n) ? pick : '0;

  // Pointer follows the winner; holds when nothing is granted.
  always_comb begin
    last_d = last_q;
    if (|grant) begin
      last_d = pick_idx;
    end
  end

  // Pointer register; reset to P-1 so input 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LAST_RST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/output_port_ctrl.sv
// Output-port controller: credit-gated round-robin arbitration over the
// input queues, one-cycle registered flit launch to the downstream queue,
// and a downstream credit counter with a sticky overflow flag.
module output_port_ctrl
  import output_port_ctrl_pkg::*;
#(
  parameter int unsigned FW      = DEF_FW,
  parameter int unsigned P       = DEF_P,
  parameter int unsigned B       = DEF_B,
  parameter int unsigned CREDITS = 1 << B
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [P-1:0]  req,
  input  logic [P*FW-1:0] flit_in,
  output logic [P-1:0]  grant,
  output logic          flit_out_wr,
  output logic [FW-1:0] flit_out,
  input  logic          credit_in,
  output logic [B:0]    credit_cnt,
  output logic          cred_err
);

  localparam logic [B:0] CRED_MAX = (B + 1)'(CREDITS);
  localparam logic [B:0] CRED_ONE = (B + 1)'(1);

  logic [B:0]    credit_q, credit_d;
  logic          err_q, err_d;
  logic          wr_q, wr_d;
  logic [FW-1:0] flit_q, flit_d;
  logic [FW-1:0] flit_sel;
  logic          has_credit;
  logic          granted;

  assign has_credit = (credit_q != '0);

  rr_arbiter #(
    .P(P)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .advance(has_credit),
    .grant  (grant)
  );

  assign granted = |grant;

  // Crossbar lane select; grant is one-hot so OR-ing the lanes is exact.
  always_comb begin
    flit_sel = '0;
    for (int unsigned i = 0; i < P; i++) begin
      if (grant[i]) begin
        flit_sel = flit_sel | flit_in[i*FW +: FW];
      end
    end
  end

  // Launch register: capture on grant, otherwise hold data and drop valid.
  always_comb begin
    wr_d   = granted;
    flit_d = granted ? flit_sel : flit_q;
  end

  // Credit bookkeeping: grant spends, credit_in refunds, both cancel;
  // a refund at full count saturates and latches the error flag.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    unique case ({granted, credit_in})
      2'b10: credit_d = credit_q - CRED_ONE;
      2'b01: begin
        if (credit_q == CRED_MAX) begin
          err_d = 1'b1;
        end else begin
          credit_d = credit_q + CRED_ONE;
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  // State registers; asynchronous reset drops any in-flight flit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= CRED_MAX;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      flit_q   <= '0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      flit_q   <= flit_d;
    end
  end

  assign flit_out_wr = wr_q;
  assign flit_out    = flit_q;
  assign credit_cnt  = credit_q;
  assign cred_err    = err_q;

endmodule

// File: tb/tb_output_port_ctrl.sv
// Directed bench for output_port_ctrl with a flit scoreboard and a small
// reference model of the round-robin pointer and credit counter.
module tb_output_port_ctrl;

  localparam int unsigned FW      = 64;
  localparam int unsigned P       = 7;
  localparam int unsigned B       = 4;
  localparam int unsigned CREDITS = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [P-1:0]    req;
  logic [P*FW-1:0] flit_in;
  logic [P-1:0]    grant;
  logic            flit_out_wr;
  logic [FW-1:0]   flit_out;
  logic            credit_in;
  logic [B:0]      credit_cnt;
  logic            cred_err;

  output_port_ctrl #(
    .FW(FW),
    .P(P),
    .B(B),
    .CREDITS(CREDITS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .flit_in    (flit_in),
    .grant      (grant),
    .flit_out_wr(flit_out_wr),
    .flit_out   (flit_out),
    .credit_in  (credit_in),
    .credit_cnt (credit_cnt),
    .cred_err   (cred_err)
  );

  always #5 clk = ~clk;

  int            nchk = 0;
  int            nerr = 0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] lane[P];
  int unsigned   m_last;
  int unsigned   m_cred;
  logic          m_err;
  logic [FW-1:0] m_flit;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arbiter: index of the first requester after 'last', or -1.
  function automatic int model_pick(input logic [P-1:0] r, input int unsigned last,
                                    input int unsigned cred);
    logic [P-1:0] sh;
    int unsigned  k;
    if (cred == 0) return -1;
    for (int unsigned off = 1; off <= P; off++) begin
      k  = (last + off) % P;
      sh = r >> k;
      if (sh[0]) return int'(k);
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = P - 1;
    m_cred = CREDITS;
    m_err  = 1'b0;
    m_flit = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '1;
    credit_in = 1'b0;
    flit_in   = '0;
    #1;
    check("grant_in_reset", 64'(grant), 64'(0));
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive, check combinational grant, clock, check registered outputs.
  task automatic cycle(input logic [P-1:0] r, input logic ci, output logic [P-1:0] g_seen);
    int           pk;
    logic [P-1:0] eg;
    req       = r;
    credit_in = ci;
    for (int i = 0; i < int'(P); i++) begin
      lane[i]              = {$urandom, $urandom};
      flit_in[i*FW +: FW]  = lane[i];
    end
    #1;
    pk = model_pick(r, m_last, m_cred);
    eg = (pk < 0) ? '0 : (P'(1) << pk);
    check("grant", 64'(grant), 64'(eg));
    g_seen = grant;
    if (pk >= 0) begin
      exp_q.push_back(lane[pk]);
      m_last = pk;
    end
    if (pk >= 0 && !ci) begin
      m_cred = m_cred - 1;
    end else if (pk < 0 && ci) begin
      if (m_cred == CREDITS) m_err = 1'b1;
      else m_cred = m_cred + 1;
    end
    @(posedge clk);
    #1;
    check("flit_out_wr", 64'(flit_out_wr), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      m_flit = exp_q.pop_front();
      check("flit_out", flit_out, m_flit);
    end else begin
      check("flit_out_hold", flit_out, m_flit);
    end
    check("credit_cnt", 64'(credit_cnt), 64'(m_cred));
    check("cred_err", 64'(cred_err), 64'(m_err));
  endtask

  initial begin
    logic [P-1:0] g;
    logic [2:0]   hist;
    int           ngr;

    // Reset values
    do_reset();
    check("rst_wr", 64'(flit_out_wr), 64'(0));
    check("rst_flit", flit_out, 64'(0));
    check("rst_credit", 64'(credit_cnt), 64'(16));
    check("rst_err", 64'(cred_err), 64'(0));
    check("rst_grant", 64'(grant), 64'(0));

    // Single request from input 2
    cycle(7'b0000100, 1'b0, g);
    check("single_grant", 64'(g), 64'(7'b0000100));
    check("single_credit", 64'(credit_cnt), 64'(15));
    cycle('0, 1'b0, g);

    // Round-robin over all requesters
    do_reset();
    for (int unsigned k = 0; k < 8; k++) begin
      cycle('1, 1'b0, g);
      check("rr_order", 64'(g), 64'(P'(1) << (k % P)));
    end
    check("rr_credit_end", 64'(credit_cnt), 64'(8));

    // Credit exhaustion and single-credit refill
    do_reset();
    ngr = 0;
    for (int k = 0; k < 17; k++) begin
      cycle(7'b0000001, 1'b0, g);
      if (g != '0) ngr++;
    end
    check("exhaust_grants", 64'(ngr), 64'(16));
    check("exhaust_last_grant", 64'(g), 64'(0));
    check("exhaust_credit", 64'(credit_cnt), 64'(0));
    cycle(7'b0000001, 1'b1, g);
    check("refill_no_bypass", 64'(g), 64'(0));
    check("refill_credit", 64'(credit_cnt), 64'(1));
    cycle(7'b0000001, 1'b0, g);
    check("refill_grant", 64'(g), 64'(7'b0000001));
    cycle(7'b0000001, 1'b0, g);
    check("refill_spent", 64'(g), 64'(0));

    // Simultaneous grant and credit return, then streaming with echoed credits
    do_reset();
    for (int k = 0; k < 11; k++) cycle(7'b0000001, 1'b0, g);
    check("sim_pre_credit", 64'(credit_cnt), 64'(5));
    cycle(7'b0000001, 1'b1, g);
    check("sim_grant", 64'(g), 64'(7'b0000001));
    check("sim_credit", 64'(credit_cnt), 64'(5));
    hist = '0;
    ngr  = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(7'b0001010, hist[2], g);
      if (g != '0) ngr++;
      hist = {hist[1:0], flit_out_wr};
    end
    check("stream_no_stall", 64'(ngr), 64'(20));

    // Credit overflow is sticky until reset
    do_reset();
    cycle('0, 1'b1, g);
    check("ovf_credit", 64'(credit_cnt), 64'(16));
    check("ovf_err", 64'(cred_err), 64'(1));
    for (int k = 0; k < 3; k++) cycle('0, 1'b0, g);
    cycle(7'b0100000, 1'b1, g);
    check("ovf_sticky", 64'(cred_err), 64'(1));
    do_reset();
    check("ovf_cleared", 64'(cred_err), 64'(0));

    // Asynchronous reset while a flit is being launched
    do_reset();
    cycle('0, 1'b1, g);
    cycle(7'b0001000, 1'b0, g);
    check("mid_wr_high", 64'(flit_out_wr), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_wr", 64'(flit_out_wr), 64'(0));
    check("async_grant", 64'(grant), 64'(0));
    check("async_credit", 64'(credit_cnt), 64'(16));
    check("async_err", 64'(cred_err), 64'(0));
    check("async_flit", flit_out, 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle('1, 1'b0, g);
    check("post_reset_first", 64'(g), 64'(7'b0000001));
    cycle('0, 1'b0, g);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
